pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline (IF, IF/ID, ID, ID/EX, EX, EX/MEM, MEM, MEM/WB, WB).
//  Detects load-use hazards, freezes the front of the pipe while a multi-cycle HI/LO op (mult/madd/msub) occupies EX,
//  and flushes wrong-path instructions when a branch resolves taken in MEM.
//  Drives the write-enable, bubble and flush inputs of PC and the pipeline registers; keeps a saturating stall-cycle counter.
// PARAMETERS
//  MUL_CYCLES  4   cycles a HI/LO op occupies EX (>=1); 1 = single-cycle, MUL_WAIT never entered
//  CNT_W       16  width of StallCycles
// PORTS
//  Clk          in   1      clock, rising edge
//  Rst          in   1      asynchronous, active-low reset
//  IDRs         in   5      rs field of the instruction in ID
//  IDRt         in   5      rt field of the instruction in ID
//  IDUsesRt     in   1      ID instruction reads rt as a source
//  IDIsMult     in   1      ID instruction is a multi-cycle HI/LO op
//  EXMemRead    in   1      instruction in EX is a load
//  EXRt         in   5      destination register of the load in EX
//  MEMBranchTaken in 1      branch in MEM resolved taken this cycle
//  StallClear   in   1      synchronous clear of StallCycles
//  PCWrite      out  1      PC update enable
//  IFIDWrite    out  1      IF/ID load enable
//  IDEXWrite    out  1      ID/EX load enable
//  IDEXBubble   out  1      load all-zero controls into ID/EX
//  EXMEMBubble  out  1      load all-zero controls into EX/MEM
//  IFIDFlush    out  1      clear IF/ID
//  IDEXFlush    out  1      clear ID/EX
//  EXMEMFlush   out  1      clear EX/MEM
//  HiLoBusy     out  1      HI/LO op in progress
//  State        out  2      0=RUN, 1=MUL_WAIT (2,3 unused, decode as RUN)
//  StallCycles  out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Reset (Rst=0, async): State=RUN, MulCnt=0, StallCycles=0; outputs are the RUN decode of current inputs.
//  Defaults: all Write=1, all Bubble/Flush=0, HiLoBusy=0. All hazard outputs combinational from state+inputs (0 latency).
//  LoadUse = EXMemRead & EXRt!=0 & (EXRt==IDRs | (IDUsesRt & EXRt==IDRt)).
//  Priority, every state: Flush > MUL_WAIT freeze > LoadUse > Mult entry.
//  Flush (MEMBranchTaken=1): IFIDFlush=IDEXFlush=EXMEMFlush=1, all Write=1, no bubbles; next State=RUN, MulCnt=0.
//   A HI/LO op in EX is younger than the branch: abort it. HiLoBusy=0 in the flush cycle.
//  RUN, LoadUse: PCWrite=IFIDWrite=0, IDEXBubble=1 for exactly one cycle; State stays RUN; IDIsMult ignored this cycle.
//  RUN, !LoadUse & IDIsMult & MUL_CYCLES>1: op advances to EX normally; next State=MUL_WAIT, MulCnt=MUL_CYCLES-1.
//  MUL_WAIT: PCWrite=IFIDWrite=IDEXWrite=0, EXMEMBubble=1, HiLoBusy=1; LoadUse and IDIsMult ignored.
//   MulCnt decrements each cycle; when MulCnt==1, next State=RUN (op leaves EX on the following edge).
//   Total freeze = MUL_CYCLES-1 cycles.
//  StallCycles: +1 on each edge with PCWrite=0 and no flush; saturates at all-ones.
//   StallClear wins over increment (result 0).
//  State encodings 2/3 (illegal): treat as RUN, recover to RUN on next edge.
//  Reset asserted mid-MUL_WAIT: immediate return to RUN; the pipeline registers are reset by their own logic.
// TESTING
//  1 lw $5 in EX (EXMemRead=1, EXRt=5), ID IDRs=5 -> 1 cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; StallCycles=1.
//  2 EXRt=0 with IDRs=0; also EXRt=7, IDRt=7, IDUsesRt=0 -> no stall in either case.
//  3 IDIsMult=1, MUL_CYCLES=4 -> State=MUL_WAIT for 3 cycles (HiLoBusy=1, EXMEMBubble=1); then RUN; StallCycles=3.
//  4 MEMBranchTaken=1 on 2nd MUL_WAIT cycle -> all three flushes=1 that cycle; next cycle State=RUN, HiLoBusy=0.
//  5 LoadUse+IDIsMult+MEMBranchTaken same cycle -> flush only, no bubble, State stays RUN.
//  6 Force StallCycles to 0xFFFE, stall 3 cycles -> holds 0xFFFF; StallClear=1 during a stall -> 0.
//    Async Rst low mid-MUL_WAIT -> State=0 immediately.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline.
// Handshake note: there is no valid/ready pair here; every control output is a
// pure function of the registered state and the current-cycle hazard inputs, so
// the pipeline registers see them in the same cycle (zero latency).
module pipeline_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic             IDUsesRt,
  input  logic             IDIsMult,
  input  logic             EXMemRead,
  input  logic [4:0]       EXRt,
  input  logic             MEMBranchTaken,
  input  logic             StallClear,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             IDEXBubble,
  output logic             EXMEMBubble,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             HiLoBusy,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCycles
);

  // Wide enough to hold MUL_CYCLES-1 (the first freeze count loaded).
  localparam int MW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;
  logic             in_wait;

  // A load in EX feeds a source of the instruction in ID; $0 never creates a hazard.
  assign load_use = EXMemRead && (EXRt != 5'd0) &&
                    ((EXRt == IDRs) || (IDUsesRt && (EXRt == IDRt)));

  // Encodings 2 and 3 are never produced; they decode as RUN and fall back to RUN.
  assign in_wait = (state_q == ST_MUL_WAIT);

  // State and multiply-occupancy counter register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Next state and hazard controls; priority is flush, freeze, load-use, mult entry.
  always_comb begin
    state_d     = ST_RUN;
    mul_cnt_d   = '0;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    EXMEMFlush  = 1'b0;
    HiLoBusy    = 1'b0;
    if (MEMBranchTaken) begin
      // Everything behind the branch is wrong-path, including a HI/LO op in EX.
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      EXMEMFlush = 1'b1;
    end else if (in_wait) begin
      // Hold the front of the pipe while the HI/LO op keeps EX busy.
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMBubble = 1'b1;
      HiLoBusy    = 1'b1;
      if (mul_cnt_q > MW'(1)) begin
        state_d   = ST_MUL_WAIT;
        mul_cnt_d = mul_cnt_q - MW'(1);
      end
    end else if (load_use) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (IDIsMult && (MUL_CYCLES > 1)) begin
      // The op moves into EX on this edge and stays there MUL_CYCLES-1 more cycles.
      state_d   = ST_MUL_WAIT;
      mul_cnt_d = MW'(MUL_CYCLES - 1);
    end
  end

  // Saturating stall-cycle counter; clear has priority over counting.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_q <= '0;
    end else if (StallClear) begin
      stall_q <= '0;
    end else if (!PCWrite && !MEMBranchTaken && !(&stall_q)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign State       = state_q;
  assign StallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_sequencer;

  localparam int MC  = 4;
  localparam int W   = 16;
  localparam int SW  = 4;

  localparam logic [8:0] C_RUN   = 9'b111_00_000_0;
  localparam logic [8:0] C_LU    = 9'b001_10_000_0;
  localparam logic [8:0] C_WAIT  = 9'b000_01_000_1;
  localparam logic [8:0] C_FLUSH = 9'b111_00_111_0;

  // clock/reset block
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic [4:0] IDRs, IDRt, EXRt;
  logic       IDUsesRt, IDIsMult, EXMemRead, MEMBranchTaken, StallClear;

  logic         pcw, ifidw, idexw, idexb, exmemb, ifidf, idexf, exmemf, hilo;
  logic [1:0]   state;
  logic [W-1:0] stall;
  logic         s_pcw, s_ifidw, s_idexw, s_idexb, s_exmemb, s_ifidf, s_idexf, s_exmemf, s_hilo;
  logic [1:0]   s_state;
  logic [SW-1:0] s_stall;

  wire [8:0] ctl   = {pcw, ifidw, idexw, idexb, exmemb, ifidf, idexf, exmemf, hilo};
  wire [8:0] s_ctl = {s_pcw, s_ifidw, s_idexw, s_idexb, s_exmemb, s_ifidf, s_idexf, s_exmemf, s_hilo};

  pipeline_sequencer #(.MUL_CYCLES(MC), .CNT_W(W)) u_dut (
    .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
    .IDIsMult(IDIsMult), .EXMemRead(EXMemRead), .EXRt(EXRt),
    .MEMBranchTaken(MEMBranchTaken), .StallClear(StallClear),
    .PCWrite(pcw), .IFIDWrite(ifidw), .IDEXWrite(idexw), .IDEXBubble(idexb),
    .EXMEMBubble(exmemb), .IFIDFlush(ifidf), .IDEXFlush(idexf), .EXMEMFlush(exmemf),
    .HiLoBusy(hilo), .State(state), .StallCycles(stall)
  );

  // Single-cycle multiplier and narrow counter: saturation and no-MUL_WAIT checks.
  pipeline_sequencer #(.MUL_CYCLES(1), .CNT_W(SW)) u_small (
    .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
    .IDIsMult(IDIsMult), .EXMemRead(EXMemRead), .EXRt(EXRt),
    .MEMBranchTaken(MEMBranchTaken), .StallClear(StallClear),
    .PCWrite(s_pcw), .IFIDWrite(s_ifidw), .IDEXWrite(s_idexw), .IDEXBubble(s_idexb),
    .EXMEMBubble(s_exmemb), .IFIDFlush(s_ifidf), .IDEXFlush(s_idexf), .EXMEMFlush(s_exmemf),
    .HiLoBusy(s_hilo), .State(s_state), .StallCycles(s_stall)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model: remaining freeze cycles and stall counts
  int m_wait  = 0;
  int m_stall = 0;
  int m_small = 0;

  function automatic logic [8:0] exp_ctl(input int wait_left);
    logic lu;
    lu = EXMemRead && (EXRt != 0) && (EXRt == IDRs || (IDUsesRt && EXRt == IDRt));
    if (MEMBranchTaken) return C_FLUSH;
    if (wait_left > 0)  return C_WAIT;
    if (lu)             return C_LU;
    return C_RUN;
  endfunction

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    logic [8:0] e, es;
    e  = exp_ctl(m_wait);
    es = exp_ctl(0);
    if (StallClear) m_stall = 0;
    else if (!e[8] && m_stall < (1 << W) - 1) m_stall++;
    if (StallClear) m_small = 0;
    else if (!es[8] && m_small < (1 << SW) - 1) m_small++;
    if (MEMBranchTaken) m_wait = 0;
    else if (m_wait > 0) m_wait--;
    else if (e == C_RUN && IDIsMult && MC > 1) m_wait = MC - 1;
  endtask

  // driver tasks
  task automatic set_idle();
    IDRs = 5'd1; IDRt = 5'd2; IDUsesRt = 1'b0; IDIsMult = 1'b0;
    EXMemRead = 1'b0; EXRt = 5'd0; MEMBranchTaken = 1'b0; StallClear = 1'b0;
  endtask

  task automatic set_lw_hazard();
    EXMemRead = 1'b1; EXRt = 5'd5; IDRs = 5'd5;
  endtask

  // Clock edge with model update; returns at the next falling edge.
  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    set_idle();
    set_lw_hazard();
    Rst = 1'b0;
    #2;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (stall !== '0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall); end
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL reset_decode got=%b exp=%b", ctl, C_LU); end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total++; if (stall !== '0) begin bad++; $display("FAIL reset_hold_stall got=%0d exp=0", stall); end
    set_idle();
    Rst = 1'b1;
    m_wait = 0; m_stall = 0; m_small = 0;
    #1;
  endtask

  task automatic test_load_use();
    set_lw_hazard();
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    set_idle();
    #1;
    total++; if (stall !== 16'd1) begin bad++; $display("FAIL lu_stall got=%0d exp=1", stall); end
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_after got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_no_stall();
    EXMemRead = 1'b1; EXRt = 5'd0; IDRs = 5'd0;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL ns_r0 got=%b exp=%b", ctl, C_RUN); end
    tick();
    EXRt = 5'd7; IDRt = 5'd7; IDRs = 5'd3; IDUsesRt = 1'b0;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL ns_rt_unused got=%b exp=%b", ctl, C_RUN); end
    tick();
    IDUsesRt = 1'b1;
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL ns_rt_used got=%b exp=%b", ctl, C_LU); end
    tick();
    set_idle();
    #1;
    total++; if (stall !== W'(m_stall)) begin bad++; $display("FAIL ns_stall got=%0d exp=%0d", stall, m_stall); end
  endtask

  task automatic test_mult();
    int start;
    start = m_stall;
    IDIsMult = 1'b1;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL mul_entry got=%b exp=%b", ctl, C_RUN); end
    tick();
    set_idle();
    for (int i = 0; i < MC - 1; i++) begin
      #1;
      total++; if (state !== 2'd1) begin bad++; $display("FAIL mul_state%0d got=%0d exp=1", i, state); end
      total++; if (ctl !== C_WAIT) begin bad++; $display("FAIL mul_ctl%0d got=%b exp=%b", i, ctl, C_WAIT); end
      tick();
    end
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL mul_exit got=%0d exp=0", state); end
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL mul_exit_ctl got=%b exp=%b", ctl, C_RUN); end
    total++; if (stall !== W'(start + MC - 1)) begin bad++; $display("FAIL mul_stall got=%0d exp=%0d", stall, start + MC - 1); end
  endtask

  task automatic test_flush_in_wait();
    int start;
    start = m_stall;
    IDIsMult = 1'b1;
    tick();
    set_idle();
    #1;
    total++; if (hilo !== 1'b1) begin bad++; $display("FAIL fw_busy got=%b exp=1", hilo); end
    tick();
    MEMBranchTaken = 1'b1;
    #1;
    total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL fw_flush got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    set_idle();
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL fw_state got=%0d exp=0", state); end
    total++; if (hilo !== 1'b0) begin bad++; $display("FAIL fw_busy_after got=%b exp=0", hilo); end
    total++; if (stall !== W'(start + 1)) begin bad++; $display("FAIL fw_stall got=%0d exp=%0d", stall, start + 1); end
  endtask

  task automatic test_priority();
    int start;
    start = m_stall;
    set_lw_hazard();
    IDIsMult = 1'b1; MEMBranchTaken = 1'b1;
    #1;
    total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL pri_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    set_idle();
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL pri_state got=%0d exp=0", state); end
    total++; if (stall !== W'(start)) begin bad++; $display("FAIL pri_stall got=%0d exp=%0d", stall, start); end
  endtask

  task automatic test_saturate();
    set_lw_hazard();
    IDIsMult = 1'b1;
    repeat (20) tick();
    #1;
    total++; if (s_stall !== 4'hF) begin bad++; $display("FAIL sat_small got=%0d exp=15", s_stall); end
    total++; if (s_state !== 2'd0) begin bad++; $display("FAIL sat_small_state got=%0d exp=0", s_state); end
    total++; if (stall !== W'(m_stall)) begin bad++; $display("FAIL sat_main got=%0d exp=%0d", stall, m_stall); end
    StallClear = 1'b1;
    tick();
    StallClear = 1'b0;
    #1;
    total++; if (s_stall !== '0) begin bad++; $display("FAIL clr_small got=%0d exp=0", s_stall); end
    total++; if (stall !== '0) begin bad++; $display("FAIL clr_main got=%0d exp=0", stall); end
    set_idle();
    tick();
  endtask

  task automatic test_async_reset();
    IDIsMult = 1'b1;
    tick();
    set_idle();
    #1;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL ar_pre got=%0d exp=1", state); end
    #1;
    Rst = 1'b0;
    m_wait = 0; m_stall = 0; m_small = 0;
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL ar_state got=%0d exp=0", state); end
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL ar_ctl got=%b exp=%b", ctl, C_RUN); end
    total++; if (stall !== '0) begin bad++; $display("FAIL ar_stall got=%0d exp=0", stall); end
    #1;
    Rst = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic [8:0] e, es;
    for (int i = 0; i < 400; i++) begin
      IDRs           = 5'($urandom_range(0, 3));
      IDRt           = 5'($urandom_range(0, 3));
      EXRt           = 5'($urandom_range(0, 3));
      IDUsesRt       = 1'($urandom_range(0, 1));
      EXMemRead      = 1'($urandom_range(0, 1));
      IDIsMult       = ($urandom_range(0, 5) == 0);
      MEMBranchTaken = ($urandom_range(0, 9) == 0);
      StallClear     = ($urandom_range(0, 24) == 0);
      #1;
      e  = exp_ctl(m_wait);
      es = exp_ctl(0);
      total++; if (ctl !== e) begin bad++; $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i, ctl, e); end
      total++; if (state !== ((m_wait > 0) ? 2'd1 : 2'd0)) begin bad++; $display("FAIL rnd_state[%0d] got=%0d exp_wait=%0d", i, state, m_wait); end
      total++; if (stall !== W'(m_stall)) begin bad++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", i, stall, m_stall); end
      total++; if (s_ctl !== es) begin bad++; $display("FAIL rnd_sctl[%0d] got=%b exp=%b", i, s_ctl, es); end
      total++; if (s_stall !== SW'(m_small)) begin bad++; $display("FAIL rnd_sstall[%0d] got=%0d exp=%0d", i, s_stall, m_small); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_mult();
    test_flush_in_wait();
    test_priority();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
